// File: rtl/auction_stream_engine.sv
// Streaming second-price auction: tracks top two bids per round, emits winner index and clearing price.
// Optional reserve price enabled by defining AUCTION_RESERVE_EN (adds reserve input and res_nosale output).
module auction_stream_engine #(
  parameter  int N_BID = 4,
  parameter  int W     = 16,
  localparam int IDX_W = $clog2(N_BID)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             bid_valid,
  output logic             bid_ready,
  input  logic [W-1:0]     bid_value,
  input  logic             bid_last,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [IDX_W-1:0] res_winner,
  output logic [W-1:0]     res_price,
  output logic [IDX_W:0]   res_count,
  output logic             res_trunc
`ifdef AUCTION_RESERVE_EN
  ,
  input  logic [W-1:0]     reserve,
  output logic             res_nosale
`endif
);

  typedef enum logic {COLLECT = 1'b0, RESULT = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [W-1:0]     max_q, max_d;
  logic [W-1:0]     sec_q, sec_d;
  logic [IDX_W:0]   cnt_q, cnt_d;
  logic [IDX_W-1:0] win_q, win_d;

  logic [IDX_W-1:0] res_win_q, res_win_d;
  logic [W-1:0]     res_price_q, res_price_d;
  logic [IDX_W:0]   res_cnt_q, res_cnt_d;
  logic             res_trunc_q, res_trunc_d;

  logic             accept;
  logic             close;
  logic             met;
  logic [IDX_W:0]   cnt_inc;
  logic [IDX_W-1:0] idx;

`ifdef AUCTION_RESERVE_EN
  logic [W-1:0]     rsv_q, rsv_d;
  logic [1:0]       met_q, met_d;
  logic             res_nosale_q, res_nosale_d;
  logic [W-1:0]     eff_rsv;
`endif

  // rst gates ready combinationally so no bid is taken while reset is asserted.
  assign bid_ready = ~rst & (state_q == COLLECT);
  assign res_valid = (state_q == RESULT);
  assign accept    = bid_valid & bid_ready;
  assign cnt_inc   = cnt_q + (IDX_W+1)'(1);
  assign idx       = cnt_q[IDX_W-1:0];
  assign close     = accept & (bid_last | (cnt_inc == (IDX_W+1)'(N_BID)));

`ifdef AUCTION_RESERVE_EN
  // Reserve is latched on the first accept, so that bid compares against the live port value.
  assign eff_rsv = (cnt_q == '0) ? reserve : rsv_q;
  assign met     = (bid_value >= eff_rsv);
`else
  assign met     = 1'b1;
`endif

  always_comb begin
    state_d     = state_q;
    max_d       = max_q;
    sec_d       = sec_q;
    cnt_d       = cnt_q;
    win_d       = win_q;
    res_win_d   = res_win_q;
    res_price_d = res_price_q;
    res_cnt_d   = res_cnt_q;
    res_trunc_d = res_trunc_q;
`ifdef AUCTION_RESERVE_EN
    rsv_d        = rsv_q;
    met_d        = met_q;
    res_nosale_d = res_nosale_q;
`endif
    if (state_q == COLLECT) begin
      if (accept) begin
        cnt_d = cnt_inc;
        if (met) begin
          if (bid_value > max_q) begin
            sec_d = max_q;
            max_d = bid_value;
            win_d = idx;
          end else if (bid_value > sec_q) begin
            sec_d = bid_value;
          end
        end
`ifdef AUCTION_RESERVE_EN
        if (cnt_q == '0) rsv_d = reserve;
        if (met && (met_q != 2'd2)) met_d = met_q + 2'd1;
`endif
        if (close) begin
          state_d     = RESULT;
          res_win_d   = win_d;
          res_price_d = sec_d;
          res_cnt_d   = cnt_d;
          res_trunc_d = ~bid_last;
`ifdef AUCTION_RESERVE_EN
          res_nosale_d = (met_d == 2'd0);
          if (met_d == 2'd0) begin
            res_win_d   = '0;
            res_price_d = '0;
          end else if (met_d == 2'd1) begin
            res_price_d = eff_rsv;
          end else begin
            res_price_d = (sec_d > eff_rsv) ? sec_d : eff_rsv;
          end
`endif
        end
      end
    end else if (res_ready) begin
      state_d     = COLLECT;
      max_d       = '0;
      sec_d       = '0;
      cnt_d       = '0;
      win_d       = '0;
      res_trunc_d = 1'b0;
`ifdef AUCTION_RESERVE_EN
      rsv_d = '0;
      met_d = 2'd0;
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= COLLECT;
      max_q       <= '0;
      sec_q       <= '0;
      cnt_q       <= '0;
      win_q       <= '0;
      res_win_q   <= '0;
      res_price_q <= '0;
      res_cnt_q   <= '0;
      res_trunc_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      max_q       <= max_d;
      sec_q       <= sec_d;
      cnt_q       <= cnt_d;
      win_q       <= win_d;
      res_win_q   <= res_win_d;
      res_price_q <= res_price_d;
      res_cnt_q   <= res_cnt_d;
      res_trunc_q <= res_trunc_d;
    end
  end

`ifdef AUCTION_RESERVE_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsv_q        <= '0;
      met_q        <= 2'd0;
      res_nosale_q <= 1'b0;
    end else begin
      rsv_q        <= rsv_d;
      met_q        <= met_d;
      res_nosale_q <= res_nosale_d;
    end
  end

  assign res_nosale = res_nosale_q;
`endif

  assign res_winner = res_win_q;
  assign res_price  = res_price_q;
  assign res_count  = res_cnt_q;
  assign res_trunc  = res_trunc_q;

endmodule

// File: tb/tb_auction_stream_engine.sv
// Scoreboard bench for auction_stream_engine: stimulus pushes expected results, a negedge monitor pops and compares.
module tb_auction_stream_engine;
  localparam int N_BID = 4;
  localparam int W     = 16;
  localparam int IDX_W = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic             bid_valid;
  logic             bid_ready;
  logic [W-1:0]     bid_value;
  logic             bid_last;
  logic             res_valid;
  logic             res_ready;
  logic [IDX_W-1:0] res_winner;
  logic [W-1:0]     res_price;
  logic [IDX_W:0]   res_count;
  logic             res_trunc;
`ifdef AUCTION_RESERVE_EN
  logic [W-1:0]     reserve;
  logic             res_nosale;
`endif

  auction_stream_engine #(.N_BID(N_BID), .W(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .bid_valid  (bid_valid),
    .bid_ready  (bid_ready),
    .bid_value  (bid_value),
    .bid_last   (bid_last),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_winner (res_winner),
    .res_price  (res_price),
    .res_count  (res_count),
    .res_trunc  (res_trunc)
`ifdef AUCTION_RESERVE_EN
    ,
    .reserve    (reserve),
    .res_nosale (res_nosale)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [IDX_W-1:0] winner;
    logic [W-1:0]     price;
    logic [IDX_W:0]   count;
    logic             trunc;
    logic             nosale;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_exp(input int w, input int p, input int c, input int t, input int ns);
    exp_t e;
    e.winner = IDX_W'(w);
    e.price  = W'(p);
    e.count  = (IDX_W+1)'(c);
    e.trunc  = t[0];
    e.nosale = ns[0];
    exp_q.push_back(e);
  endtask

  always @(negedge clk) begin
    if (!rst && res_valid && res_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_result", 32'd1, 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check("res_winner", 32'(res_winner), 32'(mon_e.winner));
        check("res_price",  32'(res_price),  32'(mon_e.price));
        check("res_count",  32'(res_count),  32'(mon_e.count));
        check("res_trunc",  32'(res_trunc),  32'(mon_e.trunc));
`ifdef AUCTION_RESERVE_EN
        check("res_nosale", 32'(res_nosale), 32'(mon_e.nosale));
`endif
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send(input logic [W-1:0] v, input logic l);
    int waitc = 0;
    bid_value = v;
    bid_last  = l;
    bid_valid = 1'b1;
    @(negedge clk);
    while (!bid_ready && waitc < 50) begin
      waitc++;
      @(negedge clk);
    end
    if (!bid_ready) check("bid_accept_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    bid_valid = 1'b0;
    bid_last  = 1'b0;
  endtask

  task automatic drain();
    int c = 0;
    while (exp_q.size() != 0 && c < 50) begin
      @(negedge clk);
      c++;
    end
    if (exp_q.size() != 0) check("drain_timeout", 32'(exp_q.size()), 32'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    rst       = 1'b1;
    bid_valid = 1'b0;
    bid_value = '0;
    bid_last  = 1'b0;
    res_ready = 1'b1;
`ifdef AUCTION_RESERVE_EN
    reserve   = '0;
`endif
    #12;
    check("rst_bid_ready",  32'(bid_ready),  32'd0);
    check("rst_res_valid",  32'(res_valid),  32'd0);
    check("rst_res_winner", 32'(res_winner), 32'd0);
    check("rst_res_price",  32'(res_price),  32'd0);
    check("rst_res_count",  32'(res_count),  32'd0);
    check("rst_res_trunc",  32'(res_trunc),  32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("post_rst_bid_ready", 32'(bid_ready), 32'd1);
    check("post_rst_res_valid", 32'(res_valid), 32'd0);

    // Round 1: 100,300,200,50
    push_exp(1, 200, 4, 0, 0);
    send(16'd100, 1'b0);
    send(16'd300, 1'b0);
    send(16'd200, 1'b0);
    send(16'd50,  1'b1);
    check("t1_latency_res_valid", 32'(res_valid), 32'd1);
    check("t1_bid_ready_low",     32'(bid_ready), 32'd0);
    drain();

    // Tie: earlier index wins, price equals max
    push_exp(0, 500, 2, 0, 0);
    send(16'd500, 1'b0);
    send(16'd500, 1'b1);
    drain();

    // Single bid held with res_ready low
    res_ready = 1'b0;
    push_exp(0, 0, 1, 0, 0);
    send(16'h1234, 1'b1);
    repeat (5) begin
      @(negedge clk);
      check("t3_hold_res_valid", 32'(res_valid),  32'd1);
      check("t3_hold_bid_ready", 32'(bid_ready),  32'd0);
      check("t3_hold_winner",    32'(res_winner), 32'd0);
      check("t3_hold_price",     32'(res_price),  32'd0);
      check("t3_hold_count",     32'(res_count),  32'd1);
    end
    @(posedge clk);
    #1;
    res_ready = 1'b1;
    drain();

    // Truncated round; a pending bid must wait for the result to drain
    res_ready = 1'b0;
    push_exp(3, 3, 4, 1, 0);
    push_exp(0, 0, 1, 0, 0);
    send(16'd1, 1'b0);
    send(16'd2, 1'b0);
    send(16'd3, 1'b0);
    send(16'd4, 1'b0);
    bid_value = 16'd5;
    bid_last  = 1'b1;
    bid_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("t4_blocked_bid_ready", 32'(bid_ready), 32'd0);
      check("t4_hold_res_valid",    32'(res_valid), 32'd1);
      check("t4_hold_trunc",        32'(res_trunc), 32'd1);
    end
    @(posedge clk);
    #1;
    res_ready = 1'b1;
    c = 0;
    @(negedge clk);
    while (!bid_ready && c < 20) begin
      c++;
      @(negedge clk);
    end
    if (!bid_ready) check("t4_ready_return_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    bid_valid = 1'b0;
    bid_last  = 1'b0;
    drain();

    // Asynchronous reset mid-round discards partial state
    send(16'd10, 1'b0);
    send(16'd20, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    check("t5_rst_bid_ready", 32'(bid_ready), 32'd0);
    check("t5_rst_res_valid", 32'(res_valid), 32'd0);
    #3;
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("t5_post_rst_bid_ready", 32'(bid_ready), 32'd1);
    push_exp(1, 7, 2, 0, 0);
    send(16'd7, 1'b0);
    send(16'd9, 1'b1);
    drain();

`ifdef AUCTION_RESERVE_EN
    reserve = 16'd150;
    push_exp(0, 0, 2, 0, 1);
    send(16'd100, 1'b0);
    send(16'd120, 1'b1);
    drain();
    push_exp(1, 150, 2, 0, 0);
    send(16'd100, 1'b0);
    send(16'd200, 1'b1);
    drain();
    push_exp(0, 180, 2, 0, 0);
    send(16'd200, 1'b0);
    send(16'd180, 1'b1);
    drain();
`endif

    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
